// File: rtl/space_pkg.sv
// Shared screen, ship-limit and motion-FSM definitions for the player ship logic.
// Constants here are the defaults; ship_motion_ctrl exposes them as overridable parameters.
package space_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int TICK_LINE    = 480;

  localparam int X_MIN        = 16;
  localparam int X_MAX        = 608;
  localparam int X_INIT       = 304;
  localparam int STEP_SLOW    = 4;
  localparam int STEP_FAST    = 8;
  localparam int REPEAT_DELAY = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } motion_state_e;

  // One clamped move; 11-bit math leaves headroom so pos+step can never wrap.
  function automatic logic [10:0] step_pos(input logic [10:0] pos,
                                           input logic [10:0] step,
                                           input logic        go_right,
                                           input logic [10:0] lo,
                                           input logic [10:0] hi);
    logic [10:0] sum;
    sum = pos + step;
    if (go_right) begin
      return (sum > hi) ? hi : sum;
    end
    return (pos < lo + step) ? lo : pos - step;
  endfunction

endpackage

// File: rtl/ship_motion_ctrl_btn_sync.sv
// Two-flop synchroniser for one asynchronous button; output lags the pin by two clk edges.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ship_motion_ctrl.sv
// Per-frame ship movement: synchronised buttons drive a slow-step / hold / fast-repeat FSM
// that owns the clamped gunPosition register; updates land two clk after the tick line is hit.
module ship_motion_ctrl #(
  parameter int X_MIN        = space_pkg::X_MIN,
  parameter int X_MAX        = space_pkg::X_MAX,
  parameter int X_INIT       = space_pkg::X_INIT,
  parameter int STEP_SLOW    = space_pkg::STEP_SLOW,
  parameter int STEP_FAST    = space_pkg::STEP_FAST,
  parameter int REPEAT_DELAY = space_pkg::REPEAT_DELAY,
  parameter int TICK_LINE    = space_pkg::TICK_LINE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic [9:0] gunPosition,
  output logic       moveValid,
  output logic       moveDir
);

  import space_pkg::*;

  localparam int HC_W = $clog2(REPEAT_DELAY + 1);

  if (!(X_MIN <= X_INIT && X_INIT <= X_MAX && STEP_SLOW >= 1 &&
        STEP_FAST >= STEP_SLOW && REPEAT_DELAY >= 1)) begin : g_bad_params
    $error("ship_motion_ctrl: illegal parameter combination");
  end

  logic            l_s;
  logic            r_s;
  logic            tick_cond;
  logic            tick_cond_q;
  logic            tick_pulse_q;
  motion_state_e   state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [9:0]      pos_q, pos_d;
  logic            dir_q, dir_d;
  logic            valid_q, valid_d;
  logic            req_r, req_l, req_any, same_dir;
  logic            do_move, use_fast;
  logic [10:0]     next_pos;

  btn_sync u_sync_left (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (left),
    .sync_o  (l_s)
  );

  btn_sync u_sync_right (
    .clk     (clk),
    .rst_n   (reset),
    .async_i (right),
    .sync_o  (r_s)
  );

  assign tick_cond = (vPos == 10'(TICK_LINE)) && (hPos == 10'd0);

  assign req_r    = r_s & ~l_s;
  assign req_l    = l_s & ~r_s;
  assign req_any  = req_r | req_l;
  assign same_dir = (req_r == dir_q);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    dir_d      = dir_q;
    do_move    = 1'b0;
    use_fast   = 1'b0;
    if (tick_pulse_q) begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            do_move    = 1'b1;
            dir_d      = req_r;
            hold_cnt_d = '0;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (!req_any) begin
            state_d = IDLE;
          end else if (same_dir) begin
            if (hold_cnt_q == HC_W'(REPEAT_DELAY - 1)) begin
              do_move  = 1'b1;
              use_fast = 1'b1;
              state_d  = REPEAT;
            end else begin
              hold_cnt_d = hold_cnt_q + 1'b1;
            end
          end else begin
            do_move    = 1'b1;
            dir_d      = req_r;
            hold_cnt_d = '0;
          end
        end
        REPEAT: begin
          if (!req_any) begin
            state_d = IDLE;
          end else if (same_dir) begin
            do_move  = 1'b1;
            use_fast = 1'b1;
          end else begin
            do_move    = 1'b1;
            dir_d      = req_r;
            hold_cnt_d = '0;
            state_d    = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Direction comes from dir_d so a reversing move steps the new way in the same tick.
  assign next_pos = step_pos({1'b0, pos_q},
                             use_fast ? 11'(STEP_FAST) : 11'(STEP_SLOW),
                             dir_d, 11'(X_MIN), 11'(X_MAX));

  always_comb begin
    pos_d   = pos_q;
    valid_d = 1'b0;
    if (do_move) begin
      pos_d   = next_pos[9:0];
      valid_d = (next_pos[9:0] != pos_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cond_q  <= 1'b0;
      tick_pulse_q <= 1'b0;
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      pos_q        <= 10'(X_INIT);
      dir_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      tick_cond_q  <= tick_cond;
      tick_pulse_q <= tick_cond & ~tick_cond_q;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      valid_q      <= valid_d;
    end
  end

  assign gunPosition = pos_q;
  assign moveValid   = valid_q;
  assign moveDir     = dir_q;

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Directed-vector bench for ship_motion_ctrl with hand-computed positions.
module tb_ship_motion_ctrl;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       left  = 1'b0;
  logic       right = 1'b0;
  logic [9:0] hPos  = 10'd1;
  logic [9:0] vPos  = 10'd0;
  logic [9:0] gunPosition;
  logic       moveValid;
  logic       moveDir;

  int errors = 0;
  int checks = 0;

  logic [9:0] s_pos;
  logic       s_vld;
  logic       s_dir;

  always #5 clk = ~clk;

  ship_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .left        (left),
    .right       (right),
    .hPos        (hPos),
    .vPos        (vPos),
    .gunPosition (gunPosition),
    .moveValid   (moveValid),
    .moveDir     (moveDir)
  );

  // One-cycle tick line, then sample two edges later when the update lands.
  task automatic tick();
    @(posedge clk); #1;
    vPos = 10'd480; hPos = 10'd0;
    @(posedge clk); #1;
    vPos = 10'd0;   hPos = 10'd1;
    @(posedge clk); #1;
    s_pos = gunPosition; s_vld = moveValid; s_dir = moveDir;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b0; left = 1'b0; right = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      left = ~left; right = (i % 2 == 0);
      checks++; if (gunPosition !== 10'd304) begin errors++; $display("FAIL reset_pos[%0d] got %0d exp 304", i, gunPosition); end
      checks++; if (moveValid !== 1'b0) begin errors++; $display("FAIL reset_vld[%0d] got %b exp 0", i, moveValid); end
      checks++; if (moveDir !== 1'b0) begin errors++; $display("FAIL reset_dir[%0d] got %b exp 0", i, moveDir); end
    end
    left = 1'b1; right = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (gunPosition !== 10'd304) begin errors++; $display("FAIL post_release_pos got %0d exp 304", gunPosition); end
    checks++; if (moveValid !== 1'b0) begin errors++; $display("FAIL post_release_vld got %b exp 0", moveValid); end
    left = 1'b0;
    settle();
  endtask

  task automatic test_hold_right();
    right = 1'b1;
    settle();
    tick();
    checks++; if (s_pos !== 10'd308) begin errors++; $display("FAIL hold_t1_pos got %0d exp 308", s_pos); end
    checks++; if (s_vld !== 1'b1) begin errors++; $display("FAIL hold_t1_vld got %b exp 1", s_vld); end
    checks++; if (s_dir !== 1'b1) begin errors++; $display("FAIL hold_t1_dir got %b exp 1", s_dir); end
    for (int t = 2; t <= 8; t++) begin
      tick();
      checks++; if (s_pos !== 10'd308 || s_vld !== 1'b0) begin errors++; $display("FAIL hold_t%0d got pos=%0d vld=%b exp pos=308 vld=0", t, s_pos, s_vld); end
    end
    tick();
    checks++; if (s_pos !== 10'd316 || s_vld !== 1'b1) begin errors++; $display("FAIL hold_t9 got pos=%0d vld=%b exp pos=316 vld=1", s_pos, s_vld); end
    tick();
    checks++; if (s_pos !== 10'd324 || s_vld !== 1'b1) begin errors++; $display("FAIL hold_t10 got pos=%0d vld=%b exp pos=324 vld=1", s_pos, s_vld); end
    right = 1'b0;
    settle();
    tick();
    checks++; if (s_pos !== 10'd324 || s_vld !== 1'b0) begin errors++; $display("FAIL hold_release got pos=%0d vld=%b exp pos=324 vld=0", s_pos, s_vld); end
  endtask

  task automatic test_both();
    left = 1'b1; right = 1'b1;
    settle();
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++; if (s_pos !== 10'd324 || s_vld !== 1'b0) begin errors++; $display("FAIL both_t%0d got pos=%0d vld=%b exp pos=324 vld=0", t, s_pos, s_vld); end
    end
    left = 1'b0;
    settle();
    tick();
    checks++; if (s_pos !== 10'd328 || s_vld !== 1'b1) begin errors++; $display("FAIL both_then_right got pos=%0d vld=%b exp pos=328 vld=1", s_pos, s_vld); end
    right = 1'b0;
    settle();
  endtask

  task automatic test_left_wall();
    reset_dut();
    left = 1'b1;
    settle();
    tick();
    checks++; if (s_pos !== 10'd300 || s_dir !== 1'b0) begin errors++; $display("FAIL lw_t1 got pos=%0d dir=%b exp pos=300 dir=0", s_pos, s_dir); end
    repeat (7) tick();
    tick();
    checks++; if (s_pos !== 10'd292) begin errors++; $display("FAIL lw_t9 got %0d exp 292", s_pos); end
    for (int k = 1; k <= 34; k++) begin
      tick();
      checks++; if (s_pos !== 10'(292 - 8 * k)) begin errors++; $display("FAIL lw_run[%0d] got %0d exp %0d", k, s_pos, 292 - 8 * k); end
    end
    left = 1'b0;
    settle();
    tick();
    checks++; if (s_pos !== 10'd20 || s_vld !== 1'b0) begin errors++; $display("FAIL lw_idle got pos=%0d vld=%b exp pos=20 vld=0", s_pos, s_vld); end
    left = 1'b1;
    settle();
    tick();
    checks++; if (s_pos !== 10'd16 || s_vld !== 1'b1) begin errors++; $display("FAIL lw_clamp got pos=%0d vld=%b exp pos=16 vld=1", s_pos, s_vld); end
    for (int t = 2; t <= 9; t++) begin
      tick();
      checks++; if (s_pos !== 10'd16 || s_vld !== 1'b0) begin errors++; $display("FAIL lw_stuck_t%0d got pos=%0d vld=%b exp pos=16 vld=0", t, s_pos, s_vld); end
    end
    left = 1'b0; right = 1'b1;
    settle();
    tick();
    checks++; if (s_pos !== 10'd20 || s_vld !== 1'b1 || s_dir !== 1'b1) begin errors++; $display("FAIL lw_reverse got pos=%0d vld=%b dir=%b exp pos=20 vld=1 dir=1", s_pos, s_vld, s_dir); end
    right = 1'b0;
    settle();
  endtask

  task automatic test_right_wall();
    reset_dut();
    right = 1'b1;
    settle();
    repeat (9) tick();
    checks++; if (s_pos !== 10'd316) begin errors++; $display("FAIL rw_t9 got %0d exp 316", s_pos); end
    for (int k = 1; k <= 36; k++) begin
      tick();
      checks++; if (s_pos !== 10'(316 + 8 * k)) begin errors++; $display("FAIL rw_run[%0d] got %0d exp %0d", k, s_pos, 316 + 8 * k); end
    end
    tick();
    checks++; if (s_pos !== 10'd608 || s_vld !== 1'b1) begin errors++; $display("FAIL rw_clamp got pos=%0d vld=%b exp pos=608 vld=1", s_pos, s_vld); end
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++; if (s_pos !== 10'd608 || s_vld !== 1'b0) begin errors++; $display("FAIL rw_stuck[%0d] got pos=%0d vld=%b exp pos=608 vld=0", t, s_pos, s_vld); end
    end
    right = 1'b0;
    settle();
  endtask

  task automatic test_dwell();
    int pulses;
    pulses = 0;
    reset_dut();
    right = 1'b1;
    settle();
    @(posedge clk); #1;
    vPos = 10'd480; hPos = 10'd0;
    repeat (6) begin
      @(posedge clk); #1;
      if (moveValid === 1'b1) pulses++;
    end
    vPos = 10'd0; hPos = 10'd1;
    repeat (4) begin
      @(posedge clk); #1;
      if (moveValid === 1'b1) pulses++;
    end
    checks++; if (gunPosition !== 10'd308) begin errors++; $display("FAIL dwell_pos got %0d exp 308", gunPosition); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL dwell_pulses got %0d exp 1", pulses); end
    right = 1'b0;
    settle();
  endtask

  task automatic test_reset_mid_repeat();
    reset_dut();
    right = 1'b1;
    settle();
    repeat (12) tick();
    checks++; if (s_pos !== 10'd340) begin errors++; $display("FAIL mid_pre got %0d exp 340", s_pos); end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    checks++; if (gunPosition !== 10'd304) begin errors++; $display("FAIL mid_async_pos got %0d exp 304", gunPosition); end
    checks++; if (moveDir !== 1'b0 || moveValid !== 1'b0) begin errors++; $display("FAIL mid_async_flags got dir=%b vld=%b exp 0 0", moveDir, moveValid); end
    @(posedge clk); #1;
    reset = 1'b1;
    settle();
    tick();
    checks++; if (s_pos !== 10'd308 || s_vld !== 1'b1) begin errors++; $display("FAIL mid_after got pos=%0d vld=%b exp pos=308 vld=1", s_pos, s_vld); end
    right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_right();
    test_both();
    test_left_wall();
    test_right_wall();
    test_dwell();
    test_reset_mid_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ship_motion_ctrl.md
Name: ship_motion_ctrl

Overview:
- Converts the raw left/right buttons into rate-limited position updates for the player ship, once per video frame.
- Synchronises the buttons and arbitrates conflicting requests.
- Hold-to-accelerate FSM: single slow step on press, fast repeat after a hold delay.
- Owns the clamped gunPosition register consumed by the ship renderer and the bullet launcher.

Parameters:
- X_MIN, 16: leftmost legal gunPosition.
- X_MAX, 608: rightmost legal gunPosition.
- X_INIT, 304: gunPosition after reset.
- STEP_SLOW, 4: pixels per move in HOLD/first press.
- STEP_FAST, 8: pixels per move in REPEAT.
- REPEAT_DELAY, 8: same-direction frames before REPEAT (>=1).
- TICK_LINE, 480: vPos at which the frame tick fires (with hPos==0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- left  in  1  raw left button, asynchronous to clk.
- right  in  1  raw right button, asynchronous to clk.
- hPos  in  10  current horizontal scan position.
- vPos  in  10  current vertical scan position.
- gunPosition  out  10  ship x-coordinate, registered.
- moveValid  out  1  one-cycle pulse when gunPosition changed.
- moveDir  out  1  direction of last issued move (1 = right), registered.

Behaviour:
- Reset (reset==0, async):
  - gunPosition = X_INIT; moveValid = 0; moveDir = 0.
  - FSM = IDLE; holdCnt = 0; synchroniser flops = 0; tick history = 0.
  - Release is sampled on the next clk rising edge.
- Synchronisers: two flops each on left and right; 2-cycle latency; only synchronised values are used.
- Frame tick:
  - tickCond = (vPos==TICK_LINE) && (hPos==0), registered into tickCond_d.
  - tickPulse = tickCond && !tickCond_d, registered: exactly one cycle per frame regardless of how long the scan position dwells.
  - FSM and gunPosition update only on edges where tickPulse==1.
  - gunPosition therefore changes 2 clk after the tick condition first appears.
- Request decode (at tick):
  - reqR = rS && !lS; reqL = lS && !rS.
  - Both or neither asserted = no request.
- FSM (evaluated only on tick):
  - IDLE:
    - reqR/reqL -> issue STEP_SLOW move, moveDir = req, holdCnt = 0, go HOLD.
    - none -> stay IDLE.
  - HOLD:
    - Same-direction request:
      - holdCnt==REPEAT_DELAY-1 -> issue STEP_FAST move, go REPEAT.
      - else holdCnt++, no move.
    - Opposite-direction request -> issue STEP_SLOW move, flip moveDir, holdCnt = 0, stay HOLD.
    - none -> IDLE.
  - REPEAT:
    - Same direction -> STEP_FAST move each tick.
    - Opposite direction -> STEP_SLOW move, flip moveDir, holdCnt = 0, go HOLD.
    - none -> IDLE.
- Arithmetic:
  - Compute in 11 bits.
  - Right move: next = min(pos+step, X_MAX).
  - Left move: next = (pos < X_MIN+step) ? X_MIN : pos-step.
  - No wrap-around ever.
- moveValid:
  - Asserted for the single cycle after a tick in which next != pos.
  - A clamped move with zero change (ship at wall) gives moveValid = 0.
  - The FSM still transitions normally in that case.
- Reset mid-operation (any state, including REPEAT) returns immediately to reset values.
- Parameter legality, enforced by elaboration assertion:
  - X_MIN <= X_INIT <= X_MAX.
  - STEP_FAST >= STEP_SLOW >= 1.

Decomposition:
- Shared package space_pkg:
  - Screen constants (H_ACTIVE 640, V_ACTIVE 480, TICK_LINE).
  - Ship limits X_MIN/X_MAX/X_INIT.
  - FSM state enum {IDLE, HOLD, REPEAT}, 2-bit encoding.
- One sub-module btn_sync: generic 2-flop synchroniser, active-low async reset, instantiated twice.

Test Plan:
1. Reset: hold reset=0 for 5 cycles with buttons toggling -> gunPosition=304, moveValid=0, moveDir=0 throughout; after release, no movement until first tick.
2. Hold right, from 304:
   - Tick 1 -> 308, moveValid pulse, moveDir=1.
   - Ticks 2-8 -> stays 308, no pulse.
   - Tick 9 -> 316; tick 10 -> 324.
3. Both buttons held for 4 ticks from IDLE -> gunPosition unchanged, moveValid never asserted, FSM stays IDLE.
4. Left wall: drive ship to 20, hold left:
   - Next tick -> 16 with pulse.
   - Following ticks -> 16, no pulse.
   - FSM still reaches REPEAT at tick 9; mirror case at X_MAX 608.
5. Tick dwell: hold vPos=480, hPos=0 for 6 consecutive cycles with right held -> exactly one move of 4 (304 -> 308).
6. Reset mid-REPEAT (position 340) -> gunPosition=304 asynchronously, before next clk edge; after release, right held -> next tick moves 4 (slow step), not 8.
